mux3_rr_arbiter: RTL
====================

Name: mux3_rr_arbiter

Overview:
- Round-robin arbiter that shares one 3-input datapath resource between three requesters.
- Produces the 2-bit select for the downstream Mux_3to1 (encoding 00/01/10) and a one-hot grant back to the requesters.
- Enforces a maximum hold time so that one requester cannot starve the others.
- Sits between the requesters (e.g. fetch, load/store, debug/DMA ports) and the shared mux feeding memory or the ALU.

Parameters:
- MAX_HOLD, 16: maximum consecutive granted cycles while another request is pending. 0 disables preemption.
- CNT_W, $clog2(MAX_HOLD+1) (localparam): width of the hold counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  3  request per requester; held high for the whole transaction
- gnt  output  3  one-hot grant, registered; all-zero when idle
- sel  output  2  select for Mux_3to1, registered; never 2'b11
- busy  output  1  high when any gnt bit is high
- preempt  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (async, rst_n=0):
  - gnt=3'b000, sel=2'b00, busy=0, preempt=0
  - Hold counter=0; state=IDLE
  - Last-owner pointer=2, so requester 0 has top priority after reset.
- States: IDLE, GRANT.
- IDLE, when req!=0:
  - Pick the first set bit scanning from (last+1) mod 3 upward with wrap.
  - Next edge: gnt=onehot(owner), sel=owner, busy=1, counter=0, state=GRANT.
  - Latency req->gnt is 1 cycle.
- IDLE, when req==0: outputs hold. sel keeps the last owner's value so the mux input does not toggle.
- GRANT, each cycle:
  - Counter increments, saturating at MAX_HOLD.
  - Normal release: req[owner]=0 sampled. Next edge: gnt=0, busy=0, last=owner, state=IDLE. No preempt pulse.
  - Preempt: MAX_HOLD!=0, counter==MAX_HOLD-1, and any other req bit set.
    - Next edge: gnt=0, busy=0, preempt=1 for exactly one cycle, last=owner, state=IDLE.
    - The preempted requester keeps req high and competes again with lowest priority.
  - Counter reaching MAX_HOLD with no competing request: grant is kept, counter saturates. A later competing request preempts on the next cycle.
- Turnaround: every ownership change passes through exactly one IDLE cycle with gnt=0. This gives the shared resource a clean bubble; back-to-back grants to different owners are never allowed.
- Same owner re-request: if the owner drops req for one cycle and reasserts, it re-arbitrates normally. It has lowest priority only if others are requesting.
- Simultaneous requests in IDLE: rotation order decides (e.g. last=0 with req=3'b111 grants 1).
- Invariants:
  - gnt is always one-hot or zero.
  - sel==index(gnt) whenever busy=1.
  - sel is never 2'b11.
- Reset mid-GRANT: outputs clear immediately (asynchronous). Arbitration restarts with requester 0 first.
- Request glitches: only req[owner] matters while in GRANT. Non-owner req changes affect only the preemption decision.

Decomposition:
- Shared package cod_pkg holds:
  - State typedef (IDLE, GRANT).
  - Select encodings SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, matching Mux_3to1.
- One natural sub-module, rr_pick3: combinational rotate-priority encoder. Inputs req[2:0] and last[1:0]; outputs owner[1:0] and found.
- The rest (FSM, counter, output registers) lives in mux3_rr_arbiter.

Test Plan:
- Reset then req=3'b001 held 5 cycles -> gnt=001 and sel=00 one cycle after req; busy high 5 cycles; release one cycle after req drops; no preempt.
- req=3'b111 from reset, each owner drops req after 3 cycles of grant -> grant order 0,1,2, each separated by one gnt=000 cycle.
- MAX_HOLD=4: req0 held forever, req1 raised on cycle 2 of grant -> req0 granted 4 cycles; preempt pulses once; one idle cycle; gnt=010, sel=01; req0 regranted after req1 drops.
- MAX_HOLD=4: req2 alone held 20 cycles -> continuous grant, counter saturates, no preempt. req0 raised at cycle 10 -> preempt the following cycle, then gnt=001.
- rst_n pulled low mid-GRANT owning 2 -> gnt=000, sel=00, busy=0 immediately. With req=3'b101 after reset, requester 0 is granted first.
- Random req stimulus, 10k cycles -> assertions hold: gnt one-hot or zero, sel!=11, sel matches gnt when busy, no owner change without an idle cycle.

Source files
------------

// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared definitions for the three-way round-robin arbiter.
//   state_t        : arbiter FSM state (IDLE / GRANT)
//   SEL_A/B/C      : select encodings matching the downstream Mux_3to1
//   sel_to_onehot  : converts a select code into a one-hot grant vector
package mux3_rr_arbiter_pkg;

   typedef logic [0:0] state_t;

   localparam state_t IDLE  = 1'b0;
   localparam state_t GRANT = 1'b1;

   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;

   function automatic logic [2:0] sel_to_onehot(input logic [1:0] s);
      logic [2:0] oh;
      oh = 3'b000;
      case (s)
         SEL_A:   oh = 3'b001;
         SEL_B:   oh = 3'b010;
         SEL_C:   oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/mux3_rr_arbiter_if.sv
// Bus between the three requesters and the arbiter.
//   req     : one request bit per requester
//   gnt     : one-hot grant, registered; zero when idle
//   sel     : Mux_3to1 select, registered; never 2'b11
//   busy    : any grant active
//   preempt : single-cycle pulse when a grant is revoked by the hold limit
//   state   : arbiter FSM state, exported for observation
// Handshake: a requester raises req[i] and keeps it high for the whole
// transaction; it owns the shared resource for every cycle in which gnt[i]
// is high and ends the transaction by dropping req[i]. A revoked requester
// may keep req[i] high and simply waits for its next grant.
interface mux3_rr_arbiter_if;
   import mux3_rr_arbiter_pkg::*;

   logic [2:0] req;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       preempt;
   state_t     state;

   modport master (output req, input gnt, sel, busy, preempt, state);
   modport slave  (input req, output gnt, sel, busy, preempt, state);
endinterface

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// Rotating-priority encoder for three requesters.
//   req   : request vector
//   last  : index of the previous owner; scanning starts at (last+1) mod 3
//   owner : selected requester index
//   found : high when any request is present
module rr_pick3
   import mux3_rr_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [1:0] owner,
   output logic       found
);

   always_comb begin
      owner = SEL_A;
      found = |req;
      case (last)
         2'd0: begin
            if (req[1])      owner = SEL_B;
            else if (req[2]) owner = SEL_C;
            else             owner = SEL_A;
         end
         2'd1: begin
            if (req[2])      owner = SEL_C;
            else if (req[0]) owner = SEL_A;
            else             owner = SEL_B;
         end
         default: begin
            if (req[0])      owner = SEL_A;
            else if (req[1]) owner = SEL_B;
            else             owner = SEL_C;
         end
      endcase
   end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one Mux_3to1 datapath between three requesters.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of mux3_rr_arbiter_if (req in; gnt, sel, busy,
//                preempt, state out)
//   MAX_HOLD   : cycles an owner may keep the grant while another request
//                waits; 0 disables preemption
// Every ownership change passes through one IDLE cycle with gnt=0.
module mux3_rr_arbiter
   import mux3_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux3_rr_arbiter_if.slave     bus
);

   // Width kept at least 1 so MAX_HOLD=0 still elaborates.
   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   state_t           state;
   logic [1:0]       last;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       gnt_r;
   logic [1:0]       sel_r;
   logic             busy_r;
   logic             preempt_r;

   logic [1:0]       pick;
   logic             found;
   logic             owner_req;
   logic             others_req;
   logic             hold_hit;

   rr_pick3 u_pick (
      .req   (bus.req),
      .last  (last),
      .owner (pick),
      .found (found)
   );

   // gnt is the owner's one-hot in GRANT, so masking with it isolates the
   // owner's request from everybody else's.
   assign owner_req  = |(bus.req & gnt_r);
   assign others_req = |(bus.req & ~gnt_r);
   // ">=" rather than "==": once the counter has saturated, a late competitor
   // must still preempt on the next edge.
   assign hold_hit   = (MAX_HOLD != 0) && (cnt >= HOLD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 2'd2;
         cnt       <= '0;
         gnt_r     <= 3'b000;
         sel_r     <= SEL_A;
         busy_r    <= 1'b0;
         preempt_r <= 1'b0;
      end else begin
         preempt_r <= 1'b0;
         case (state)
            IDLE: begin
               // sel holds while idle so the mux input does not toggle.
               if (found) begin
                  gnt_r  <= sel_to_onehot(pick);
                  sel_r  <= pick;
                  busy_r <= 1'b1;
                  cnt    <= '0;
                  state  <= GRANT;
               end
            end
            default: begin
               if (cnt != HOLD_SAT) cnt <= cnt + 1'b1;
               if (!owner_req) begin
                  gnt_r  <= 3'b000;
                  busy_r <= 1'b0;
                  last   <= sel_r;
                  state  <= IDLE;
               end else if (hold_hit && others_req) begin
                  gnt_r     <= 3'b000;
                  busy_r    <= 1'b0;
                  preempt_r <= 1'b1;
                  last      <= sel_r;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.sel     = sel_r;
   assign bus.busy    = busy_r;
   assign bus.preempt = preempt_r;
   assign bus.state   = state;

endmodule
